uc_secuencial: RTL
==================

// Module: uc_secuencial
// PURPOSE
//  Control unit for the single-cycle microcontroller datapath (no data memory).
//  Decodes the 6-bit Opcode and z flag from the datapath and drives s_inc, s_inm, we3, wez, Op.
//  Adds a RUN/HALT/TRAP sequencer, a resume handshake and a retired-instruction counter.
//  Sits directly upstream of the datapath control inputs.
// PARAMETERS
//  ICOUNT_W  16      width of the retired-instruction counter icount
//  LDI_OP    3'b000  ALU Op code that passes operand A through (used by LDI)
// PORTS
//  clk     in   1         rising-edge clock shared with the datapath
//  reset   in   1         synchronous reset, active-high
//  Opcode  in   6         instr[15:10] from the datapath
//  z       in   1         registered zero flag from the datapath
//  resume  in   1         level; sampled only in HALT
//  s_inc   out  1         0 = PC+1; 1 = load instr[9:0] (jump)
//  s_inm   out  1         1 = ALU operand A is the immediate instr[7:0]
//  we3     out  1         register-file write enable
//  wez     out  1         z flag write enable
//  Op      out  3         ALU operation
//  halted  out  1         1 while in HALT
//  trap    out  1         1 while in TRAP
//  icount  out  ICOUNT_W  retired instructions, saturating
// BEHAVIOUR
//  Decode on Opcode[5:2]:
//   - 1ooo ALU: Op=Opcode[4:2], we3=1, wez=1, s_inm=0, s_inc=0
//   - 0001 LDI: Op=LDI_OP, s_inm=1, we3=1, wez=0, s_inc=0
//   - 0000 NOP: we3=0, wez=0, s_inc=0
//   - 0010 J: s_inc=1
//   - 0011 JZ: s_inc=z
//   - 0100 JNZ: s_inc=~z
//   - 0111 HALT: s_inc=1; the assembler places the HALT's own address in instr[9:0]
//   - 0101, 0110 illegal
//  Defaults: all jumps and HALT drive we3=0, wez=0. Op=3'b000 and s_inm=0 unless stated.
//  Control outputs are combinational from state + Opcode + z (same-cycle, zero latency).
//  z is the registered flag, so JZ/JNZ see the result of the previous wez=1 instruction.
//  State register (3 states, reset = RUN):
//   - RUN: decode as above.
//     HALT opcode -> next HALT. Illegal opcode -> next TRAP, with we3=wez=0 and s_inc=0 that cycle.
//   - HALT: Opcode ignored; we3=wez=0; halted=1.
//     resume=0: s_inc=1 (PC reloads the self-address), stay HALT.
//     resume=1: s_inc=0 (PC+1), next RUN.
//   - TRAP: we3=wez=0, s_inc=0, trap=1. resume ignored; only reset exits.
//  resume outside HALT: ignored.
//  icount: +1 per RUN cycle with a legal opcode (HALT included); never counts in HALT/TRAP.
//   Saturates at all-ones; no wrap.
//  Reset cycle (reset=1): we3=0, wez=0, s_inc=0, s_inm=0, Op=0 forced.
//   Next state RUN, icount=0, halted=0, trap=0.
//  Reset has priority over resume, illegal decode and HALT in the same cycle, including mid-HALT/TRAP.
//  halted and trap are registered-state decodes: they assert the cycle after entry.
// TESTING
//  1. reset=1 for 2 cycles, Opcode=6'b100000 -> we3=0, wez=0, icount=0, halted=0, trap=0.
//  2. RUN, Opcode=6'b101100 -> Op=3'b011, we3=1, wez=1, s_inm=0, s_inc=0; icount 0->1 next edge.
//  3. Opcode=6'b000100 -> s_inm=1, Op=LDI_OP, we3=1, wez=0.
//     Opcode=6'b001100: z=1 -> s_inc=1, z=0 -> s_inc=0.
//     Opcode=6'b010000: z=0 -> s_inc=1.
//  4. Opcode=6'b011100 -> s_inc=1; next cycle halted=1.
//     Hold 5 cycles -> icount frozen, we3=0.
//     resume=1 -> s_inc=0; next cycle halted=0.
//  5. Opcode=6'b010100 -> next cycle trap=1.
//     resume=1 for 3 cycles -> trap stays 1, we3=wez=0.
//     reset=1 -> trap=0 after the edge.
//  6. ICOUNT_W=4: 20 consecutive NOPs (6'b000000) -> icount=4'hF, no wrap.
//     Reset at cycle 10 of HALT -> RUN, icount=0.

Source files
------------

// File: rtl/uc_secuencial.sv
// -----------------------------------------------------------------------------
// uc_secuencial
//   Control unit for the single-cycle microcontroller datapath. It decodes the
//   6-bit opcode and the registered zero flag into datapath controls. A small
//   RUN/HALT/TRAP sequencer sits on top of the decoder. The unit also keeps a
//   saturating count of retired instructions.
//
// Ports
//   clk     in   1         rising-edge clock shared with the datapath
//   reset   in   1         synchronous reset, active-high
//   Opcode  in   6         instr[15:10] from the datapath
//   z       in   1         registered zero flag from the datapath
//   resume  in   1         level; only looked at while halted
//   s_inc   out  1         0 = PC+1, 1 = load instr[9:0] (jump)
//   s_inm   out  1         1 = ALU operand A is the immediate instr[7:0]
//   we3     out  1         register-file write enable
//   wez     out  1         zero-flag write enable
//   Op      out  3         ALU operation
//   halted  out  1         1 while in HALT
//   trap    out  1         1 while in TRAP
//   icount  out  ICOUNT_W  retired instructions, saturating
// -----------------------------------------------------------------------------
module uc_secuencial #(
  parameter int         ICOUNT_W = 16,
  parameter logic [2:0] LDI_OP   = 3'b000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          Opcode,
  input  logic                z,
  input  logic                resume,
  output logic                s_inc,
  output logic                s_inm,
  output logic                we3,
  output logic                wez,
  output logic [2:0]          Op,
  output logic                halted,
  output logic                trap,
  output logic [ICOUNT_W-1:0] icount
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_TRAP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ICOUNT_W-1:0] icount_q, icount_d;

  // Decoder plus sequencer. The controls are combinational from the state,
  // the opcode and z, so the datapath sees them in the same cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
    s_inc    = 1'b0;
    s_inm    = 1'b0;
    we3      = 1'b0;
    wez      = 1'b0;
    Op       = 3'b000;
    state_d  = state_q;
    icount_d = icount_q;

    if (reset) begin
      // Reset overrides every other condition, including a pending resume or
      // an illegal opcode. The controls keep their all-zero defaults here.
      state_d  = ST_RUN;
      icount_d = '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          // Each legal opcode retires one instruction; HALT counts as legal.
          // The count sticks at all-ones instead of wrapping.
          if (!(Opcode[5:2] inside {4'b0101, 4'b0110}) && icount_q != '1)
            icount_d = icount_q + ICOUNT_W'(1);

          casez (Opcode[5:2])
            4'b1???: begin            // ALU group, operation in the opcode
              Op  = Opcode[4:2];
              we3 = 1'b1;
              wez = 1'b1;
            end
            4'b0001: begin            // LDI: immediate passed through the ALU
              Op    = LDI_OP;
              s_inm = 1'b1;
              we3   = 1'b1;
            end
            4'b0000: ;                // NOP
            4'b0010: s_inc = 1'b1;    // J
            4'b0011: s_inc = z;       // JZ
            4'b0100: s_inc = ~z;      // JNZ
            4'b0111: begin
              // The HALT word jumps to its own address, so the PC holds steady.
              s_inc   = 1'b1;
              state_d = ST_HALT;
            end
            default: state_d = ST_TRAP;  // 0101 and 0110 are illegal
          endcase
        end

        ST_HALT: begin
          // Without resume the PC keeps reloading the HALT address. With
          // resume it steps past the HALT word.
          s_inc = ~resume;
          if (resume) state_d = ST_RUN;
        end

        ST_TRAP: ;                    // Only reset leaves TRAP

        default: state_d = ST_TRAP;   // Unreachable encoding; stop safely
      endcase
    end
  end

  // The reset is synchronous, so it only takes effect on the clock edge. The
  // reset values come from the next-state logic above.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so all registers update together at the edge.
    state_q  <= state_d;
    icount_q <= icount_d;
  end

  // These are registered-state decodes. They rise the cycle after entry.
  assign halted = (state_q == ST_HALT);
  assign trap   = (state_q == ST_TRAP);
  assign icount = icount_q;

endmodule
